alu_seq: RTL and testbench

- Sequencer and staging stage wrapped around the 8-bit ALU.
- Accepts one operation request per transaction and registers operand A (TMP), operand B, opcode and carry-in.
- Drives the ALU inputs from those registers, captures the ALU result into an accumulator and the ALU status into a 4-bit flags register.
- Hands the result downstream with a valid/ready handshake. Provides the carry-in feedback that chained multi-byte arithmetic needs.

---
 rtl/alu_seq.sv | 114 +++++++++++
 tb/tb_alu_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequencer/staging wrapper around the 8-bit ALU: request regs, accumulator, flags, result handshake.
// Optional accumulator forwarding into operand B is enabled by defining ALU_SEQ_ACC_FWD_EN.
module alu_seq #(
  parameter int WIDTH = 8
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             wreq_valid,
  output logic             wreq_ready,
  input  logic [2:0]       bops_in,
  input  logic [WIDTH-1:0] ba_in,
  input  logic [WIDTH-1:0] bb_in,
  input  logic             wuse_c,
  input  logic             wclf,
`ifdef ALU_SEQ_ACC_FWD_EN
  input  logic             wsel_acc,
`endif
  output logic [WIDTH-1:0] balu_a,
  output logic [WIDTH-1:0] balu_b,
  output logic             walu_ci,
  output logic [2:0]       balu_ops,
  input  logic [WIDTH-1:0] balu_c,
  input  logic             walu_co,
  input  logic             walu_eq,
  input  logic             walu_alo,
  input  logic             walu_z,
  output logic             wres_valid,
  input  logic             wres_ready,
  output logic [WIDTH-1:0] bres,
  output logic [3:0]       bflags
);

  if (WIDTH != 8) begin : g_width_chk
    $error("alu_seq: WIDTH must be 8, the ALU is 8-bit");
  end

  localparam logic [2:0] OP_NOP = 3'd7;
  localparam int         FLG_C  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             accept, capture;
  logic [WIDTH-1:0] b_src;

`ifdef ALU_SEQ_ACC_FWD_EN
  assign b_src = wsel_acc ? bres : bb_in;
`else
  assign b_src = bb_in;
`endif

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    wreq_ready = 1'b0;
    wres_valid = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        wreq_ready = 1'b1;
        if (wreq_valid) begin
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        wres_valid = 1'b1;
        if (wres_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand staging; a clear coinciding with accept wins over the stored carry.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      balu_a   <= '0;
      balu_b   <= '0;
      balu_ops <= '0;
      walu_ci  <= 1'b0;
    end else if (accept) begin
      balu_a   <= ba_in;
      balu_b   <= b_src;
      balu_ops <= bops_in;
      walu_ci  <= wuse_c & ~wclf & bflags[FLG_C];
    end
  end

  // Result capture; a flag capture on the EXEC edge takes priority over wclf.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      bres   <= '0;
      bflags <= '0;
    end else begin
      if (capture) bres <= (balu_ops == OP_NOP) ? '0 : balu_c;
      if (capture && balu_ops != OP_NOP) bflags <= {walu_co, walu_alo, walu_eq, walu_z};
      else if (wclf)                     bflags <= '0;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: behavioural ALU on the operand bus, table vectors,
// hand-written handshake/reset/clear sequences and randomized operations against a model.
module tb_alu_seq;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       wreq_valid, wreq_ready;
  logic [2:0] bops_in;
  logic [7:0] ba_in, bb_in;
  logic       wuse_c, wclf;
  logic [7:0] balu_a, balu_b, balu_c;
  logic       walu_ci;
  logic [2:0] balu_ops;
  logic       walu_co, walu_eq, walu_alo, walu_z;
  logic       wres_valid, wres_ready;
  logic [7:0] bres;
  logic [3:0] bflags;
`ifdef ALU_SEQ_ACC_FWD_EN
  logic       wsel_acc = 1'b0;
`endif

  int npass = 0;
  int ntotal = 0;
  logic [3:0] mflags = 4'h0;  // model of the stored {C,A,E,Z}

  always #5 wclk = ~wclk;

  alu_seq #(.WIDTH(8)) dut (
    .wclk(wclk), .wrst_n(wrst_n),
    .wreq_valid(wreq_valid), .wreq_ready(wreq_ready),
    .bops_in(bops_in), .ba_in(ba_in), .bb_in(bb_in),
    .wuse_c(wuse_c), .wclf(wclf),
`ifdef ALU_SEQ_ACC_FWD_EN
    .wsel_acc(wsel_acc),
`endif
    .balu_a(balu_a), .balu_b(balu_b), .walu_ci(walu_ci), .balu_ops(balu_ops),
    .balu_c(balu_c), .walu_co(walu_co), .walu_eq(walu_eq), .walu_alo(walu_alo), .walu_z(walu_z),
    .wres_valid(wres_valid), .wres_ready(wres_ready),
    .bres(bres), .bflags(bflags)
  );

  // Behavioural 8-bit ALU: returns {co, a>b, a==b, zero, result}
  function automatic logic [11:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                          input logic ci);
    int s;
    logic [7:0] r;
    logic co;
    s = 0; r = 8'h00; co = 1'b0;
    case (op)
      3'd0: begin s = int'(a) + int'(b) + int'(ci); r = 8'(s % 256); co = (s > 255); end
      3'd1: begin r = 8'((int'(a) / 2) + (ci ? 128 : 0)); co = a[0]; end
      3'd2: begin r = 8'((int'(a) * 2 + int'(ci)) % 256); co = a[7]; end
      3'd3: r = ~a;
      3'd4: r = a & b;
      3'd5: r = a | b;
      3'd6: r = a ^ b;
      default: r = 8'h00;
    endcase
    return {co, a > b, a == b, r == 8'h00, r};
  endfunction

  always_comb {walu_co, walu_alo, walu_eq, walu_z, balu_c} = ref_alu(balu_ops, balu_a, balu_b, walu_ci);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // One full transaction; clf_acc pulses wclf with the accept, clf_exe during EXEC.
  task automatic do_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic uc,
                       input logic clf_acc, input logic clf_exe);
    logic ci;
    logic [11:0] m;
    logic [7:0] er;
    if (clf_acc) mflags = 4'h0;
    ci = uc & mflags[3];
    m  = ref_alu(op, a, b, ci);
    er = (op == 3'd7) ? 8'h00 : m[7:0];
    if (op != 3'd7)   mflags = m[11:8];
    else if (clf_exe) mflags = 4'h0;
    @(negedge wclk);
    wreq_valid = 1'b1; bops_in = op; ba_in = a; bb_in = b; wuse_c = uc; wclf = clf_acc; wres_ready = 1'b0;
    @(negedge wclk);
    wreq_valid = 1'b0; wclf = clf_exe;
    chk("exec_valid", 32'(wres_valid), 32'd0);
    chk("exec_ready", 32'(wreq_ready), 32'd0);
    chk("alu_a", 32'(balu_a), 32'(a));
    chk("alu_b", 32'(balu_b), 32'(b));
    chk("alu_ops", 32'(balu_ops), 32'(op));
    chk("alu_ci", 32'(walu_ci), 32'(ci));
    @(negedge wclk);
    wclf = 1'b0;
    chk("resp_valid", 32'(wres_valid), 32'd1);
    chk("res", 32'(bres), 32'(er));
    chk("flags", 32'(bflags), 32'(mflags));
    wres_ready = 1'b1;
    @(negedge wclk);
    wres_ready = 1'b0;
    chk("done_valid", 32'(wres_valid), 32'd0);
    chk("done_ready", 32'(wreq_ready), 32'd1);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [7:0] a, b;
    logic       uc;
    logic [7:0] er;
    logic [3:0] ef;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{3'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0100};
    tbl[1]  = '{3'd0, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b1101};
    tbl[2]  = '{3'd0, 8'h00, 8'h00, 1'b1, 8'h01, 4'b0010};
    tbl[3]  = '{3'd2, 8'h81, 8'h00, 1'b0, 8'h02, 4'b1100};
    tbl[4]  = '{3'd1, 8'h01, 8'h00, 1'b0, 8'h00, 4'b1101};
    tbl[5]  = '{3'd7, 8'h33, 8'h44, 1'b0, 8'h00, 4'b1101};
    tbl[6]  = '{3'd6, 8'h5A, 8'h5A, 1'b0, 8'h00, 4'b0011};
    tbl[7]  = '{3'd6, 8'h80, 8'h01, 1'b0, 8'h81, 4'b0100};
    tbl[8]  = '{3'd4, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0100};
    tbl[9]  = '{3'd5, 8'h0F, 8'h30, 1'b0, 8'h3F, 4'b0000};
    tbl[10] = '{3'd3, 8'h00, 8'hFF, 1'b0, 8'hFF, 4'b0000};
    tbl[11] = '{3'd0, 8'h80, 8'h80, 1'b0, 8'h00, 4'b1011};
    tbl[12] = '{3'd0, 8'h01, 8'h01, 1'b1, 8'h03, 4'b0010};

    wrst_n = 1'b0; wreq_valid = 1'b0; bops_in = 3'd0; ba_in = 8'h00; bb_in = 8'h00;
    wuse_c = 1'b0; wclf = 1'b0; wres_ready = 1'b0;
    @(negedge wclk);
    chk("rst_ready", 32'(wreq_ready), 32'd1);
    chk("rst_valid", 32'(wres_valid), 32'd0);
    chk("rst_res", 32'(bres), 32'd0);
    chk("rst_flags", 32'(bflags), 32'd0);
    chk("rst_alu", 32'({balu_a, balu_b, balu_ops, walu_ci}), 32'd0);
    wrst_n = 1'b1;
    @(negedge wclk);

    for (int i = 0; i < 13; i++) begin
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].uc, 1'b0, 1'b0);
      chk($sformatf("tbl%0d_res", i), 32'(bres), 32'(tbl[i].er));
      chk($sformatf("tbl%0d_flags", i), 32'(bflags), 32'(tbl[i].ef));
    end

    // wclf in IDLE clears flags
    @(negedge wclk); wclf = 1'b1;
    @(negedge wclk); wclf = 1'b0; mflags = 4'h0;
    chk("clf_idle", 32'(bflags), 32'd0);

    // clear coinciding with accept beats the stored carry
    do_op(3'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op(3'd0, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
    chk("clf_acc_res", 32'(bres), 32'h00);
    // capture beats a clear on the EXEC edge
    do_op(3'd0, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    chk("clf_cap_flags", 32'(bflags), 32'hD);
    // carry already sampled at accept survives a later clear
    do_op(3'd0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("ci_sampled_res", 32'(bres), 32'h01);

    // backpressure in RESP with a competing request
    @(negedge wclk);
    wreq_valid = 1'b1; bops_in = 3'd0; ba_in = 8'h10; bb_in = 8'h20; wuse_c = 1'b0;
    @(negedge wclk);
    ba_in = 8'hAA; bb_in = 8'h55; bops_in = 3'd4;
    @(negedge wclk);
    mflags = ref_alu(3'd0, 8'h10, 8'h20, 1'b0) >> 8;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", 32'(wres_valid), 32'd1);
      chk("bp_ready", 32'(wreq_ready), 32'd0);
      chk("bp_res", 32'(bres), 32'h30);
      chk("bp_flags", 32'(bflags), 32'(mflags));
      chk("bp_alu_a", 32'(balu_a), 32'h10);
      @(negedge wclk);
    end
    wreq_valid = 1'b0; wres_ready = 1'b1;
    @(negedge wclk);
    wres_ready = 1'b0;
    chk("bp_rel_valid", 32'(wres_valid), 32'd0);
    chk("bp_rel_ready", 32'(wreq_ready), 32'd1);
    chk("bp_no_accept", 32'(balu_a), 32'h10);

    // reset during EXEC aborts the operation
    @(negedge wclk);
    wreq_valid = 1'b1; bops_in = 3'd0; ba_in = 8'hFF; bb_in = 8'h01; wuse_c = 1'b0;
    @(negedge wclk);
    wreq_valid = 1'b0; wrst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(wreq_ready), 32'd1);
    chk("mid_rst_valid", 32'(wres_valid), 32'd0);
    chk("mid_rst_out", 32'({bres, bflags, balu_a, balu_b, balu_ops, walu_ci}), 32'd0);
    @(negedge wclk); wrst_n = 1'b1; mflags = 4'h0;
    @(negedge wclk);
    chk("post_rst_valid", 32'(wres_valid), 32'd0);
    chk("post_rst_res", 32'(bres), 32'd0);

    // randomized operations against the model
    for (int n = 0; n < 40; n++) begin
      logic [2:0] rop;
      logic [7:0] ra, rb;
      logic ruc;
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      ruc = 1'($urandom);
      do_op(rop, ra, rb, ruc, 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
